// File: rtl/fast_tx_ts_source_if.sv
// Timestamp stream between fast_tx_ts_source and the FAST port pipeline.
// Carries {timestamp, tag, step} with a valid/ready handshake.
interface fast_tx_ts_source_if #(
    parameter int PTP_TS_WIDTH = 96,
    parameter int TAG_WIDTH    = 16
);
    logic [PTP_TS_WIDTH-1:0] m_axis_tx_ptp_ts_96;
    logic [TAG_WIDTH-1:0]    m_axis_tx_ptp_ts_tag;
    logic                    m_axis_tx_ptp_ts_step;
    logic                    m_axis_tx_ptp_ts_valid;
    logic                    m_axis_tx_ptp_ts_ready;

    modport master (
        output m_axis_tx_ptp_ts_96,
        output m_axis_tx_ptp_ts_tag,
        output m_axis_tx_ptp_ts_step,
        output m_axis_tx_ptp_ts_valid,
        input  m_axis_tx_ptp_ts_ready
    );

    modport slave (
        input  m_axis_tx_ptp_ts_96,
        input  m_axis_tx_ptp_ts_tag,
        input  m_axis_tx_ptp_ts_step,
        input  m_axis_tx_ptp_ts_valid,
        output m_axis_tx_ptp_ts_ready
    );
endinterface

// File: rtl/fast_tx_ts_source.sv
// Taps the TX AXI-Stream, timestamps every start of frame and queues {ts, tag, step}
// in a FWFT FIFO. Define FAST_TS_DROP_CNT_EN to build the saturating drop counter.
module fast_tx_ts_source #(
    parameter int PTP_TS_WIDTH = 96,
    parameter int TAG_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tap_tvalid,
    input  logic                        tap_tready,
    input  logic                        tap_tlast,
    input  logic [127:0]                tap_tuser,
    input  logic [PTP_TS_WIDTH-1:0]     ptp_ts_96,
    input  logic                        ptp_ts_step,
    fast_tx_ts_source_if.master         m_axis,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 drop_count
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = PTP_TS_WIDTH + TAG_WIDTH + 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               in_frame;
    logic               beat;
    logic               sop;
    logic               valid;
    logic               pop;
    logic               full_after_pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    // Occupancy is the pointer distance; the extra MSB separates full from empty.
    assign fifo_count = wr_ptr - rd_ptr;

    always_comb begin
        beat           = tap_tvalid & tap_tready;
        sop            = beat & ~in_frame;
        valid          = (fifo_count != '0);
        pop            = valid & m_axis.m_axis_tx_ptp_ts_ready;
        // A pop in the same cycle frees a slot, so a full queue can still accept.
        full_after_pop = (fifo_count == DEPTH_CNT) & ~pop;
        push           = sop & ~full_after_pop;
        drop           = sop & full_after_pop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_frame <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (beat) begin
                in_frame <= ~tap_tlast;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; only the pointers are,
    // and the output mux below masks stale contents while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ptp_ts_96, tap_tuser[TAG_WIDTH-1:0], ptp_ts_step};
        end
    end

    assign head = valid ? mem[rd_ptr[AW-1:0]] : '0;

    assign m_axis.m_axis_tx_ptp_ts_valid = valid;
    assign {m_axis.m_axis_tx_ptp_ts_96,
            m_axis.m_axis_tx_ptp_ts_tag,
            m_axis.m_axis_tx_ptp_ts_step} = head;

`ifdef FAST_TS_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
    logic unused_drop;
    assign unused_drop = drop;
`endif

    // Only the tag bits of the sideband are consumed.
    logic unused_tuser;
    assign unused_tuser = ^tap_tuser[127:TAG_WIDTH];

endmodule
